multicycle_main_controller: RTL and testbench

Parametrised multi-cycle control FSM. It replaces the single-cycle combinational main decoder in the cached RISC-V core. It sequences fetch, decode, execute, memory and writeback for one instruction at a time, and stalls on the cache `mem_ready` handshake. Compared with the single-cycle decoder it adds JALR, LUI and AUIPC, a memory-wait timeout with a trap state, and illegal-opcode trapping.

---
 rtl/multicycle_main_controller.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_main_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_controller.sv
// Multi-cycle main control FSM for the cached RISC-V core: sequences one instruction
// at a time through fetch/decode/execute/memory/writeback and stalls on mem_ready.
module multicycle_main_controller #(
    parameter int unsigned EN_JALR     = 1,
    parameter int unsigned EN_UPPER    = 1,
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       branch,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Last counter value before the trap fires; only meaningful when the timeout is enabled.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIM = TIMEOUT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRLINK = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [TIMEOUT_W-1:0]   wait_cnt;
    logic [TIMEOUT_W-1:0]   wait_cnt_next;
    logic                   in_wait;
    logic                   timeout_hit;
    logic                   illegal_set;

    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (illegal_set) begin
                illegal <= 1'b1;
            end
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        illegal_set   = 1'b0;
        timeout_hit   = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        imm_src       = 3'b000;
        result_src    = 2'b00;
        branch        = 1'b0;
        instr_done    = 1'b0;

        in_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
        // mem_ready has priority over an expiring counter in the same cycle.
        if ((MEM_TIMEOUT != 0) && in_wait && !mem_ready && (wait_cnt == TIMEOUT_LIM)) begin
            timeout_hit = 1'b1;
        end

        case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                imm_src     = 3'b010;
                state_next  = S_TRAP;
                illegal_set = 1'b1;
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        state_next  = S_MEMADR;
                        illegal_set = 1'b0;
                    end
                    OP_R: begin
                        state_next  = S_EXECR;
                        illegal_set = 1'b0;
                    end
                    OP_I: begin
                        state_next  = S_EXECI;
                        illegal_set = 1'b0;
                    end
                    OP_BR: begin
                        state_next  = S_BEQ;
                        illegal_set = 1'b0;
                    end
                    OP_JAL: begin
                        state_next  = S_JAL;
                        illegal_set = 1'b0;
                    end
                    OP_JALR: begin
                        if (EN_JALR != 0) begin
                            state_next  = S_JALR;
                            illegal_set = 1'b0;
                        end
                    end
                    OP_LUI: begin
                        if (EN_UPPER != 0) begin
                            state_next  = S_LUI;
                            illegal_set = 1'b0;
                        end
                    end
                    OP_AUIPC: begin
                        if (EN_UPPER != 0) begin
                            state_next  = S_AUIPC;
                            illegal_set = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OP_LOAD) begin
                    imm_src    = 3'b000;
                    state_next = S_MEMREAD;
                end else begin
                    imm_src    = 3'b001;
                    state_next = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = 3'b000;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = 2'b01;
                result_src = 2'b00;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // ALU forms OldPC+4 for the link while PC takes the target held in ALUOut.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = 3'b000;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_next = S_JALRLINK;
            end
            S_JALRLINK: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b01;
                imm_src    = 3'b100;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                imm_src    = 3'b100;
                state_next = S_ALUWB;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase

        // Counter runs only while stalled in the same wait state; any move or handshake clears it.
        if (in_wait && !mem_ready && (state_next == state)) begin
            if (wait_cnt == {TIMEOUT_W{1'b1}}) begin
                wait_cnt_next = wait_cnt;
            end else begin
                wait_cnt_next = wait_cnt + 1'b1;
            end
        end

        if (!rst_n) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            branch     = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Randomised bench for multicycle_main_controller: per-instruction state paths are
// planned from opcode and wait counts, then compared cycle by cycle.
module tb_multicycle_main_controller;

    localparam int TO = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;

    logic       a_pc_write, a_ir_write, a_adr_src, a_mem_read, a_mem_write, a_reg_write;
    logic [1:0] a_alu_src_a, a_alu_src_b, a_alu_op, a_result_src;
    logic [2:0] a_imm_src;
    logic       a_branch, a_instr_done, a_illegal, a_mem_timeout;
    logic [3:0] a_state;

    logic       b_pc_write, b_ir_write, b_adr_src, b_mem_read, b_mem_write, b_reg_write;
    logic [1:0] b_alu_src_a, b_alu_src_b, b_alu_op, b_result_src;
    logic [2:0] b_imm_src;
    logic       b_branch, b_instr_done, b_illegal, b_mem_timeout;
    logic [3:0] b_state;

    always #5 clk = ~clk;

    multicycle_main_controller #(
        .EN_JALR(1), .EN_UPPER(1), .TIMEOUT_W(8), .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .ir_write(a_ir_write), .adr_src(a_adr_src),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .reg_write(a_reg_write),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
        .imm_src(a_imm_src), .result_src(a_result_src), .branch(a_branch),
        .instr_done(a_instr_done), .illegal(a_illegal), .mem_timeout(a_mem_timeout),
        .state_o(a_state)
    );

    multicycle_main_controller #(
        .EN_JALR(0), .EN_UPPER(0), .TIMEOUT_W(8), .MEM_TIMEOUT(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .ir_write(b_ir_write), .adr_src(b_adr_src),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .reg_write(b_reg_write),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
        .imm_src(b_imm_src), .result_src(b_result_src), .branch(b_branch),
        .instr_done(b_instr_done), .illegal(b_illegal), .mem_timeout(b_mem_timeout),
        .state_o(b_state)
    );

    logic [18:0] a_ctrl;
    logic [6:0]  a_strb, b_strb;
    assign a_ctrl = {a_pc_write, a_ir_write, a_adr_src, a_mem_read, a_mem_write, a_reg_write,
                     a_alu_src_a, a_alu_src_b, a_alu_op, a_imm_src, a_result_src,
                     a_branch, a_instr_done};
    assign a_strb = {a_pc_write, a_ir_write, a_mem_read, a_mem_write, a_reg_write,
                     a_branch, a_instr_done};
    assign b_strb = {b_pc_write, b_ir_write, b_mem_read, b_mem_write, b_reg_write,
                     b_branch, b_instr_done};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int st;
        bit rdy;
        bit ill;
        bit tmo;
    } step_t;

    step_t plan[$];
    bit    exp_ill = 1'b0;
    bit    exp_tmo = 1'b0;

    function automatic bit legal_a(input logic [6:0] o);
        return o inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    // Control word expected in each state, straight from the state output table.
    function automatic logic [18:0] exp_ctrl(input int st, input logic [6:0] opc, input bit rdy);
        logic pcw, irw, adr, mr, mw, rw, br, done;
        logic [1:0] a, b, op, res;
        logic [2:0] imm;
        {pcw, irw, adr, mr, mw, rw, br, done} = 8'd0;
        {a, b, op, res} = 8'd0;
        imm = 3'd0;
        case (st)
            0:  begin mr = 1; b = 2; res = 2; pcw = rdy; irw = rdy; end
            1:  begin a = 1; b = 1; imm = 2; end
            2:  begin a = 2; b = 1; imm = (opc == OP_LOAD) ? 3'd0 : 3'd1; end
            3:  begin adr = 1; mr = 1; end
            4:  begin res = 1; rw = 1; done = 1; end
            5:  begin adr = 1; mw = 1; done = rdy; end
            6:  begin a = 2; op = 2; end
            7:  begin a = 2; b = 1; op = 2; end
            8:  begin rw = 1; done = 1; end
            9:  begin a = 2; op = 1; br = 1; done = 1; end
            10: begin a = 1; b = 2; pcw = 1; end
            11: begin a = 2; b = 1; res = 2; pcw = 1; end
            12: begin a = 1; b = 2; end
            13: begin a = 3; b = 1; imm = 4; end
            14: begin a = 1; b = 1; imm = 4; end
            default: ;
        endcase
        return {pcw, irw, adr, mr, mw, rw, a, b, op, imm, res, br, done};
    endfunction

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push(input int st, input bit rdy);
        step_t s;
        s.st = st;
        s.rdy = rdy;
        s.ill = exp_ill;
        s.tmo = exp_tmo;
        plan.push_back(s);
    endtask

    task automatic add_wait(input int st, input int w, output bit trapped);
        if (w >= TO) begin
            repeat (TO) push(st, 1'b0);
            exp_tmo = 1'b1;
            trapped = 1'b1;
        end else begin
            repeat (w) push(st, 1'b0);
            push(st, 1'b1);
            trapped = 1'b0;
        end
    endtask

    task automatic plan_instr(input logic [6:0] opc, input int wf, input int wm, output bit trapped);
        bit t;
        plan.delete();
        add_wait(0, wf, t);
        if (!t) begin
            push(1, rnd());
            case (opc)
                OP_LOAD:  begin push(2, rnd()); add_wait(3, wm, t); if (!t) push(4, rnd()); end
                OP_STORE: begin push(2, rnd()); add_wait(5, wm, t); end
                OP_R:     begin push(6, rnd()); push(8, rnd()); end
                OP_I:     begin push(7, rnd()); push(8, rnd()); end
                OP_BR:    push(9, rnd());
                OP_JAL:   begin push(10, rnd()); push(8, rnd()); end
                OP_JALR:  begin push(11, rnd()); push(12, rnd()); push(8, rnd()); end
                OP_LUI:   begin push(13, rnd()); push(8, rnd()); end
                OP_AUIPC: begin push(14, rnd()); push(8, rnd()); end
                default:  begin exp_ill = 1'b1; t = 1'b1; end
            endcase
        end
        if (t) repeat (3) push(15, rnd());
        trapped = t;
    endtask

    // Entered and left on a falling edge; each step is one clock cycle.
    task automatic run_plan(input logic [6:0] opc);
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            mem_ready = s.rdy;
            opcode = (s.st == 0) ? 7'($urandom) : opc;
            #1;
            check($sformatf("state(op=%b)", opc), 32'(a_state), 32'(s.st));
            check($sformatf("ctrl@s%0d", s.st), 32'(a_ctrl), 32'(exp_ctrl(s.st, opc, s.rdy)));
            check("illegal", 32'(a_illegal), 32'(s.ill));
            check("mem_timeout", 32'(a_mem_timeout), 32'(s.tmo));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 7'($urandom);
        #1;
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_strobes", 32'(a_strb), 32'd0);
        check("rst_flags", 32'({a_illegal, a_mem_timeout}), 32'd0);
        @(negedge clk);
        check("rst_hold_state", 32'(a_state), 32'd0);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        exp_ill = 1'b0;
        exp_tmo = 1'b0;
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 60) return 0;
        if (r < 95) return int'($urandom_range(1, TO - 1));
        return int'($urandom_range(TO, TO + 2));
    endfunction

    function automatic logic [6:0] pick_opcode();
        logic [6:0] o;
        case ($urandom_range(0, 11))
            0: o = OP_LOAD;
            1: o = OP_STORE;
            2: o = OP_R;
            3: o = OP_I;
            4: o = OP_BR;
            5: o = OP_JAL;
            6: o = OP_JALR;
            7: o = OP_LUI;
            8: o = OP_AUIPC;
            default: begin
                o = 7'($urandom);
                while (legal_a(o)) o = 7'($urandom);
            end
        endcase
        return o;
    endfunction

    task automatic run_one(input logic [6:0] opc, input int wf, input int wm);
        bit t;
        plan_instr(opc, wf, wm, t);
        run_plan(opc);
        if (t) do_reset();
    endtask

    initial begin
        #2;
        do_reset();

        // Directed: add, load with 3 waits, store with waits, timeout edge in FETCH and MEMWRITE.
        run_one(OP_R, 0, 0);
        run_one(OP_LOAD, 0, 3);
        run_one(OP_STORE, 0, 2);
        run_one(OP_R, TO - 1, 0);
        run_one(OP_R, TO, 0);
        run_one(OP_STORE, 0, TO);
        run_one(OP_LUI, 0, 0);
        run_one(7'b1111111, 0, 0);

        // JALR abandoned by an asynchronous reset in JALRLINK.
        begin
            bit t;
            plan_instr(OP_JALR, 0, 0, t);
            plan.delete(plan.size() - 1);
            plan.delete(plan.size() - 1);
            run_plan(OP_JALR);
            mem_ready = 1'b0;
            opcode = OP_JALR;
            #1;
            check("jalrlink_state", 32'(a_state), 32'd12);
            #1;
            rst_n = 1'b0;
            #1;
            check("async_rst_state", 32'(a_state), 32'd0);
            check("async_rst_strobes", 32'(a_strb), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            exp_ill = 1'b0;
            exp_tmo = 1'b0;
            run_one(OP_I, 2, 0);
        end

        for (int i = 0; i < 150; i++) begin
            run_one(pick_opcode(), pick_wait(), pick_wait());
        end

        // Variant without JALR/upper decoding and with the timeout disabled.
        do_reset();
        mem_ready = 1'b1;
        opcode = OP_LUI;
        #1;
        check("b_fetch", 32'(b_state), 32'd0);
        @(negedge clk); #1;
        check("b_decode", 32'(b_state), 32'd1);
        @(negedge clk); #1;
        check("b_lui_trap", 32'(b_state), 32'd15);
        check("b_lui_illegal", 32'(b_illegal), 32'd1);
        check("b_trap_strobes", 32'(b_strb), 32'd0);
        check("b_no_timeout", 32'(b_mem_timeout), 32'd0);
        @(negedge clk);

        do_reset();
        mem_ready = 1'b1;
        opcode = OP_JALR;
        @(negedge clk);
        @(negedge clk); #1;
        check("b_jalr_trap", 32'(b_state), 32'd15);
        check("b_jalr_illegal", 32'(b_illegal), 32'd1);
        @(negedge clk);

        do_reset();
        mem_ready = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        check("b_long_wait_state", 32'(b_state), 32'd0);
        check("b_long_wait_tmo", 32'(b_mem_timeout), 32'd0);
        check("a_long_wait_trap", 32'(a_state), 32'd15);
        check("a_long_wait_tmo", 32'(a_mem_timeout), 32'd1);
        mem_ready = 1'b1;
        @(negedge clk); #1;
        check("b_after_wait_decode", 32'(b_state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
